// File: rtl/input_module_if.sv
// Control/status bundle for input_module: IO strobe, raw switch and key inputs,
// and the ready/overrun/led status returned to the system.
// The shared tri-state data bus stays a plain inout port on the module so the
// driver and its resolution live on one ordinary net.
interface input_module_if;
  logic       IO;
  logic [7:0] sw;
  logic       key_n;
  logic       in_ready;
  logic       in_overrun;
  logic [7:0] led;

  modport master (
    output IO,
    output sw,
    output key_n,
    input  in_ready,
    input  in_overrun,
    input  led
  );

  modport slave (
    input  IO,
    input  sw,
    input  key_n,
    output in_ready,
    output in_overrun,
    output led
  );
endinterface

// File: rtl/input_module.sv
// Debounced switch-capture input port. A debounced press of key_n captures
// the synchronized switches into a register that the CPU reads over a shared
// tri-state bus while IO is high. Reads clear in_ready/in_overrun; a capture
// over an unread value sets the sticky overrun flag.
module input_module #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst,
  inout  wire  [7:0]          bus,
  input_module_if.slave       ctl
);

  typedef enum logic [1:0] {StIdle, StDbPress, StHeld, StDbRelease} state_e;

  localparam logic [7:0] CntLast = 8'(DEBOUNCE_CYCLES - 1);

  logic       key_meta_q, key_sync_q;
  logic [7:0] sw_meta_q, sw_sync_q;
  logic       key_s;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       capture;

  logic [7:0] data_q, data_d;
  logic       in_ready_q, in_ready_d;
  logic       in_overrun_q, in_overrun_d;
  logic       read;

  // Two-flop synchronizers; the key resets to released (key_n high).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_meta_q <= 1'b1;
      key_sync_q <= 1'b1;
      sw_meta_q  <= 8'h00;
      sw_sync_q  <= 8'h00;
    end else begin
      key_meta_q <= ctl.key_n;
      key_sync_q <= key_meta_q;
      sw_meta_q  <= ctl.sw;
      sw_sync_q  <= sw_meta_q;
    end
  end

  assign key_s = ~key_sync_q;
  assign read  = ctl.IO;

  // Debounce FSM next-state: press and release must each be stable for
  // DEBOUNCE_CYCLES consecutive cycles; capture fires once per press.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (key_s) begin
          state_d = StDbPress;
          cnt_d   = 8'h00;
        end
      end
      StDbPress: begin
        if (!key_s) begin
          state_d = StIdle;
        end else if (cnt_q == CntLast) begin
          capture = 1'b1;
          state_d = StHeld;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StHeld: begin
        if (!key_s) begin
          state_d = StDbRelease;
          cnt_d   = 8'h00;
        end
      end
      StDbRelease: begin
        if (key_s) begin
          state_d = StHeld;
        end else if (cnt_q == CntLast) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Register/flag next-state. A read on the capture edge sees the old value
  // on the bus, so it consumes that one and leaves the new one pending.
  always_comb begin
    data_d       = data_q;
    in_ready_d   = in_ready_q;
    in_overrun_d = in_overrun_q;
    if (capture) begin
      data_d       = sw_sync_q;
      in_ready_d   = 1'b1;
      in_overrun_d = read ? 1'b0 : (in_overrun_q | in_ready_q);
    end else if (read) begin
      in_ready_d   = 1'b0;
      in_overrun_d = 1'b0;
    end
  end

  // FSM, counter and input register state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= 8'h00;
      data_q       <= 8'h00;
      in_ready_q   <= 1'b0;
      in_overrun_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      data_q       <= data_d;
      in_ready_q   <= in_ready_d;
      in_overrun_q <= in_overrun_d;
    end
  end

  assign bus            = ctl.IO ? data_q : 8'hzz;
  assign ctl.led        = data_q;
  assign ctl.in_ready   = in_ready_q;
  assign ctl.in_overrun = in_overrun_q;

endmodule

// File: tb/tb_input_module.sv
// Directed bench for input_module with DEBOUNCE_CYCLES=4: table of press
// records plus hand-written sequences for latency, bounce, read, same-edge
// capture/read and reset-abort corner cases. The bus has pull-ups, so an
// undriven bus reads 8'hFF.
module tb_input_module;

  localparam int unsigned Dc = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  wire  [7:0] bus;

  input_module_if u_if ();

  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup pu (bus[g]);
  end

  input_module #(.DEBOUNCE_CYCLES(Dc)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .ctl (u_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0] sw;
    int         low;
    logic       do_read;
    logic [7:0] exp_led;
    logic       exp_ready;
    logic       exp_ovr;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one rising edge and settle past it.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic [7:0] s, input int low);
    u_if.sw = s;
    tick(3);
    u_if.key_n = 1'b0;
    tick(low);
    u_if.key_n = 1'b1;
    tick(12);
  endtask

  task automatic do_read(input string name, input logic [7:0] exp);
    u_if.IO = 1'b1;
    #1;
    check({name, " bus"}, bus, exp);
    tick();
    u_if.IO = 1'b0;
    #1;
    check({name, " ready cleared"}, {7'd0, u_if.in_ready}, 8'd0);
    check({name, " ovr cleared"}, {7'd0, u_if.in_overrun}, 8'd0);
    check({name, " bus released"}, bus, 8'hFF);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    u_if.IO    = 1'b0;
    u_if.sw    = 8'h00;
    u_if.key_n = 1'b1;

    vecs[0] = '{8'h11, 12, 1'b0, 8'h11, 1'b1, 1'b0};
    vecs[1] = '{8'h99, 12, 1'b1, 8'h99, 1'b1, 1'b1};
    vecs[2] = '{8'h3C, 4,  1'b0, 8'h99, 1'b0, 1'b0};
    vecs[3] = '{8'h3C, 5,  1'b0, 8'h3C, 1'b1, 1'b0};
    vecs[4] = '{8'h11, 5,  1'b1, 8'h11, 1'b1, 1'b1};
    vecs[5] = '{8'hA5, 20, 1'b1, 8'hA5, 1'b1, 1'b0};

    tick(3);
    check("reset led", u_if.led, 8'h00);
    check("reset ready", {7'd0, u_if.in_ready}, 8'd0);
    check("reset ovr", {7'd0, u_if.in_overrun}, 8'd0);
    check("reset bus z", bus, 8'hFF);
    rst = 1'b0;
    tick(2);

    // Capture latency and single capture while held.
    u_if.sw = 8'h2A;
    tick(3);
    u_if.key_n = 1'b0;
    tick(6);
    check("latency edge6 ready", {7'd0, u_if.in_ready}, 8'd0);
    tick();
    check("latency edge7 ready", {7'd0, u_if.in_ready}, 8'd1);
    check("latency led", u_if.led, 8'h2A);
    tick(13);
    u_if.key_n = 1'b1;
    tick(12);
    check("held no 2nd capture", {7'd0, u_if.in_overrun}, 8'd0);
    check("held ready", {7'd0, u_if.in_ready}, 8'd1);

    do_read("read 2A", 8'h2A);

    // Bounce: 3 low / 1 high, five times.
    u_if.sw = 8'hEE;
    for (int r = 0; r < 5; r++) begin
      u_if.key_n = 1'b0;
      tick(3);
      u_if.key_n = 1'b1;
      tick(1);
    end
    tick(12);
    check("bounce ready", {7'd0, u_if.in_ready}, 8'd0);
    check("bounce led", u_if.led, 8'h2A);

    // Table-driven presses.
    for (int i = 0; i < 6; i++) begin
      press(vecs[i].sw, vecs[i].low);
      check($sformatf("vec%0d led", i), u_if.led, vecs[i].exp_led);
      check($sformatf("vec%0d ready", i), {7'd0, u_if.in_ready}, {7'd0, vecs[i].exp_ready});
      check($sformatf("vec%0d ovr", i), {7'd0, u_if.in_overrun}, {7'd0, vecs[i].exp_ovr});
      if (vecs[i].do_read) do_read($sformatf("vec%0d read", i), vecs[i].exp_led);
    end

    // Read on the exact capture edge.
    press(8'h11, 12);
    check("same-edge pre led", u_if.led, 8'h11);
    u_if.sw = 8'h55;
    tick(3);
    u_if.key_n = 1'b0;
    tick(6);
    u_if.IO = 1'b1;
    #1;
    check("same-edge bus old", bus, 8'h11);
    tick();
    u_if.IO = 1'b0;
    #1;
    check("same-edge led", u_if.led, 8'h55);
    check("same-edge ready", {7'd0, u_if.in_ready}, 8'd1);
    check("same-edge ovr", {7'd0, u_if.in_overrun}, 8'd0);
    u_if.key_n = 1'b1;
    tick(12);
    do_read("read 55", 8'h55);

    // Reset in the middle of a press.
    u_if.sw = 8'h77;
    tick(3);
    u_if.key_n = 1'b0;
    tick(5);
    rst = 1'b1;
    #1;
    check("midrst led", u_if.led, 8'h00);
    check("midrst ready", {7'd0, u_if.in_ready}, 8'd0);
    check("midrst ovr", {7'd0, u_if.in_overrun}, 8'd0);
    tick();
    rst = 1'b0;
    tick(6);
    check("postrst edge6 ready", {7'd0, u_if.in_ready}, 8'd0);
    check("postrst edge6 led", u_if.led, 8'h00);
    tick();
    check("postrst edge7 ready", {7'd0, u_if.in_ready}, 8'd1);
    check("postrst edge7 led", u_if.led, 8'h77);
    u_if.key_n = 1'b1;
    tick(12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/input_module.md
INPUT_MODULE -- requirements
Module: input_module

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16, giving the number of consecutive stable clk cycles required to accept a key press or release (legal range 2..255).
REQ-002 SHALL use one clock; reset is asynchronous and active-high (ports clk, rst).
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 bus  inout  8  shared CPU data bus.
REQ-006 IO  input  1  control signal; high means the input register drives bus this cycle.
REQ-007 sw  input  8  user switches; asynchronous to clk.
REQ-008 key_n  input  1  enter pushbutton; active-low, asynchronous, bouncing.
REQ-009 in_ready  output  1  a captured value is waiting and has not been read.
REQ-010 in_overrun  output  1  sticky flag: a capture replaced an unread value.
REQ-011 led  output  8  current contents of the input register.

Function
REQ-012 SHALL pass key_n and sw each through a 2-flop synchronizer; key_s = NOT synchronized key_n (1 = pressed).
REQ-013 SHALL run a 4-state FSM: IDLE, DB_PRESS, HELD, DB_RELEASE, with an 8-bit counter cnt.
REQ-014 IDLE: key_s=1 -> DB_PRESS with cnt<=0; otherwise stay in IDLE.
REQ-015 DB_PRESS: key_s=0 -> IDLE (bounce rejected, no capture); key_s=1 with cnt=DEBOUNCE_CYCLES-1 -> capture, then HELD; otherwise cnt<=cnt+1.
REQ-016 HELD: key_s=0 -> DB_RELEASE with cnt<=0; otherwise stay in HELD; a held key SHALL NOT produce a second capture.
REQ-017 DB_RELEASE: key_s=1 -> HELD; key_s=0 with cnt=DEBOUNCE_CYCLES-1 -> IDLE; otherwise cnt<=cnt+1.
REQ-018 Capture SHALL load the input register with synchronized sw and set in_ready<=1.
REQ-019 Capture latency SHALL be exactly DEBOUNCE_CYCLES+3 rising edges from the first edge that samples key_n low, with key_n held low throughout.
REQ-020 bus SHALL be driven with the input register value combinationally while IO=1, and SHALL be high-Z while IO=0.
REQ-021 A read is any rising edge with IO=1; a read SHALL clear in_ready and in_overrun.
REQ-022 Capture with in_ready=1 and no read on the same edge SHALL set in_overrun<=1, and the new value SHALL replace the old one.
REQ-023 Capture and read on the same edge: the bus carries the old value during that cycle; after the edge the register holds the new value, in_ready=1 and in_overrun=0.
REQ-024 A read with in_ready=0 SHALL drive the current register value and leave the flags at 0.
REQ-025 led SHALL equal the input register at all times.
REQ-026 The module SHALL never drive bus while IO=0, whatever the FSM state.

Reset
REQ-027 While rst=1: FSM=IDLE, cnt=0, register=0, in_ready=0, in_overrun=0, key synchronizer=released, sw synchronizer=0, bus high-Z unless IO=1.
REQ-028 Reset during DB_PRESS or HELD SHALL abort with no capture; after release, a still-pressed key SHALL need a full new debounce before capture.

Verification (DEBOUNCE_CYCLES=4)
REQ-029 Sequence: sw=8'h2A, key_n low for 20 cycles, then high. Required: in_ready rises on edge 7, led=8'h2A, and exactly one capture occurs.
REQ-030 Sequence: key_n pulses low for 3 cycles, then high for 1 cycle, repeated 5 times. Required: no capture and in_ready stays 0.
REQ-031 Sequence: after capture of 8'h2A, IO=1 for one cycle. Required: bus=8'h2A during that cycle, then in_ready=0, and bus is Z once IO=0.
REQ-032 Sequence: capture 8'h11, no read, then a valid press with sw=8'h99. Required: led=8'h99, in_ready=1, in_overrun=1; a subsequent read clears both flags.
REQ-033 Sequence: IO=1 on the exact capture edge of 8'h55 while holding 8'h11. Required: bus=8'h11 that cycle, then led=8'h55, in_ready=1, in_overrun=0.
REQ-034 Sequence: rst pulsed at cycle 5 of a press. Required: all outputs zero and no capture until 7 edges after rst falls with the key still held.
